multicycle_control: RTL and testbench

- Parametrised, sequential successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the same control set as the single-cycle decoder, plus PC/IR enables.
- Handles a memory ready handshake with a timeout, conditional branch resolution, and halt at instruction boundaries.
- Sits between the instruction register/PC and the datapath of the multi-cycle core.

---
 rtl/multicycle_control_if.sv | 66 ++++++
 rtl/multicycle_control.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// ---------------------
// Bundles the signals between the multi-cycle control FSM and the rest of
// the core (instruction register / PC on one side, datapath and memory
// strobes on the other).
//
// Signals:
//   opcode          instruction opcode presented by the instruction register
//   cond_flag       branch condition from the datapath
//   mem_ready       memory completion for the current fetch/read/write
//   halt_req        stop request, honoured at instruction boundaries
//   ir_write        load instruction register
//   pc_write        update PC
//   reg_write       register file write enable
//   mem_write       memory write strobe
//   mem_read        memory read strobe (fetch or load)
//   use_ea          select effective address
//   alu_op          ALU operation
//   link_src        link/branch source select
//   mem_to_reg      writeback from memory
//   branch_control  0 none, 1 conditional, 2 subroutine, 3 return
//   state           current FSM state encoding
//   illegal_op      sticky illegal-opcode flag
//   mem_error       sticky memory-timeout flag
//
// Modports:
//   master  the control unit (drives the control set)
//   slave   the datapath/memory side (drives opcode, flags and handshake)

interface multicycle_control_if #(
    parameter int OPCODE_W = 4,
    parameter int ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                cond_flag;
    logic                mem_ready;
    logic                halt_req;

    logic                ir_write;
    logic                pc_write;
    logic                reg_write;
    logic                mem_write;
    logic                mem_read;
    logic                use_ea;
    logic [ALUOP_W-1:0]  alu_op;
    logic                link_src;
    logic                mem_to_reg;
    logic [1:0]          branch_control;
    logic [2:0]          state;
    logic                illegal_op;
    logic                mem_error;

    modport master (
        input  opcode, cond_flag, mem_ready, halt_req,
        output ir_write, pc_write, reg_write, mem_write, mem_read, use_ea,
               alu_op, link_src, mem_to_reg, branch_control, state,
               illegal_op, mem_error
    );

    modport slave (
        output opcode, cond_flag, mem_ready, halt_req,
        input  ir_write, pc_write, reg_write, mem_write, mem_read, use_ea,
               alu_op, link_src, mem_to_reg, branch_control, state,
               illegal_op, mem_error
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// ------------------
// Multi-cycle successor to the single-cycle opcode decoder. Each instruction
// is stepped through FETCH / DECODE / EXEC / MEM / WB and the same control
// set as the single-cycle decoder is produced, plus PC and IR enables.
// Memory accesses use a ready handshake guarded by a wait-cycle timeout,
// conditional branches resolve in EXEC, and halt requests are honoured only
// between instructions.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    multicycle_control_if.master (opcode/flags/handshake in,
//          control strobes, state and sticky flags out)
//
// Parameters:
//   OPCODE_W     opcode width; values >= 16 are illegal and behave as NOP
//   ALUOP_W      alu_op width; alu_op is op_q truncated/zero-extended
//   MEM_TIMEOUT  wait cycles without mem_ready before ERROR; 0 disables

module multicycle_control #(
    parameter int OPCODE_W    = 4,
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    // Wide enough to hold MEM_TIMEOUT without wrapping before the compare.
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [OPCODE_W-1:0] op_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic                illegal_flag;
    logic                mem_error_flag;

    logic [31:0]         opcode_ext;
    logic [31:0]         op_q_ext;
    logic                opcode_illegal;
    logic [3:0]          op_idx;
    logic                timeout_hit;
    logic                go_fetch;

    logic                ir_write;
    logic                pc_write;
    logic                reg_write;
    logic                mem_write;
    logic                mem_read;
    logic                use_ea;
    logic [ALUOP_W-1:0]  alu_op;
    logic                link_src;
    logic                mem_to_reg;
    logic [1:0]          branch_control;

    // Opcodes are compared in a fixed 32-bit space so the ">= 16 is
    // illegal" rule works for any OPCODE_W. An illegal latched opcode maps
    // to index 0 so EXEC treats it exactly like NOP.
    assign opcode_ext     = 32'(bus.opcode);
    assign op_q_ext       = 32'(op_q);
    assign opcode_illegal = (opcode_ext >= 32'd16);
    assign op_idx         = (op_q_ext < 32'd16) ? op_q_ext[3:0] : 4'd0;

    assign timeout_hit = (MEM_TIMEOUT > 0) && !bus.mem_ready &&
                         (32'(wait_cnt) == 32'(MEM_TIMEOUT));

    // State register, latched opcode, sticky flags and the memory wait
    // counter. The counter restarts whenever FETCH or MEM is entered and
    // saturates so a disabled timeout can never wrap into a false match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= '0;
            wait_cnt       <= '0;
            illegal_flag   <= 1'b0;
            mem_error_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                op_q <= bus.opcode;
                if (opcode_illegal) begin
                    illegal_flag <= 1'b1;
                end
            end
            if (state_next == ERROR && state != ERROR) begin
                mem_error_flag <= 1'b1;
            end
            if ((state_next == FETCH || state_next == MEM) && state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == FETCH || state == MEM) && !bus.mem_ready &&
                         wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Next-state and control outputs. Every transition that would land in
    // FETCH raises go_fetch; the halt check at the bottom redirects those
    // to IDLE while leaving the cycle's pc_write untouched.
    always_comb begin
        state_next     = state;
        go_fetch       = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        use_ea         = 1'b0;
        alu_op         = '0;
        link_src       = 1'b0;
        mem_to_reg     = 1'b0;
        branch_control = 2'd0;

        case (state)
            IDLE: begin
                if (!bus.halt_req) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = DECODE;
                end else if (timeout_hit) begin
                    state_next = ERROR;
                end
            end
            DECODE: begin
                state_next = EXEC;
            end
            EXEC: begin
                alu_op = ALUOP_W'(op_q);
                case (op_idx)
                    4'd0, 4'd6: begin
                        pc_write = 1'b1;
                        go_fetch = 1'b1;
                    end
                    4'd9, 4'd11, 4'd12: begin
                        link_src = 1'b1;
                        use_ea   = 1'b1;
                        pc_write = 1'b1;
                        go_fetch = 1'b1;
                        if (op_idx == 4'd11) begin
                            branch_control = 2'd2;
                        end else if (op_idx == 4'd12) begin
                            branch_control = 2'd3;
                        end
                    end
                    4'd10: begin
                        link_src       = 1'b1;
                        use_ea         = 1'b1;
                        branch_control = 2'd1;
                        pc_write       = bus.cond_flag;
                        go_fetch       = 1'b1;
                    end
                    4'd13, 4'd14: begin
                        use_ea     = 1'b1;
                        state_next = MEM;
                    end
                    4'd15: begin
                        use_ea     = 1'b1;
                        state_next = WB;
                    end
                    default: begin
                        state_next = WB;
                    end
                endcase
            end
            MEM: begin
                use_ea = 1'b1;
                if (op_idx == 4'd13) begin
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    if (bus.mem_ready) begin
                        state_next = WB;
                    end else if (timeout_hit) begin
                        state_next = ERROR;
                    end
                end else begin
                    mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        pc_write = 1'b1;
                        go_fetch = 1'b1;
                    end else if (timeout_hit) begin
                        state_next = ERROR;
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = (op_idx == 4'd13);
                use_ea     = (op_idx == 4'd13) || (op_idx == 4'd15);
                go_fetch   = 1'b1;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = ERROR;
            end
        endcase

        if (go_fetch) begin
            state_next = bus.halt_req ? IDLE : FETCH;
        end
    end

    assign bus.ir_write       = ir_write;
    assign bus.pc_write       = pc_write;
    assign bus.reg_write      = reg_write;
    assign bus.mem_write      = mem_write;
    assign bus.mem_read       = mem_read;
    assign bus.use_ea         = use_ea;
    assign bus.alu_op         = alu_op;
    assign bus.link_src       = link_src;
    assign bus.mem_to_reg     = mem_to_reg;
    assign bus.branch_control = branch_control;
    assign bus.state          = state;
    assign bus.illegal_op     = illegal_flag;
    assign bus.mem_error      = mem_error_flag;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// ---------------------
// Directed bench for multicycle_control. Two instances share clk/reset:
// dut4 (4-bit opcodes, timeout 15) carries the main instruction sequences,
// dut5 (5-bit opcodes) is parked in IDLE by halt_req until the illegal
// opcode sequence at the end.
//
// Strobe vectors are packed as
//   {ir_write, pc_write, reg_write, mem_write, mem_read, use_ea, link_src, mem_to_reg}
// and sticky flags as {illegal_op, mem_error}.

module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPCODE_W(4), .ALUOP_W(4)) b4 ();
    multicycle_control_if #(.OPCODE_W(5), .ALUOP_W(4)) b5 ();

    multicycle_control #(.OPCODE_W(4), .ALUOP_W(4), .MEM_TIMEOUT(15)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    multicycle_control #(.OPCODE_W(5), .ALUOP_W(4), .MEM_TIMEOUT(15)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (b5)
    );

    logic [7:0] st4, sb4, alu4, bc4, flg4;
    logic [7:0] st5, sb5, alu5, bc5, flg5;

    assign st4  = {5'd0, b4.state};
    assign sb4  = {b4.ir_write, b4.pc_write, b4.reg_write, b4.mem_write,
                   b4.mem_read, b4.use_ea, b4.link_src, b4.mem_to_reg};
    assign alu4 = {4'd0, b4.alu_op};
    assign bc4  = {6'd0, b4.branch_control};
    assign flg4 = {6'd0, b4.illegal_op, b4.mem_error};

    assign st5  = {5'd0, b5.state};
    assign sb5  = {b5.ir_write, b5.pc_write, b5.reg_write, b5.mem_write,
                   b5.mem_read, b5.use_ea, b5.link_src, b5.mem_to_reg};
    assign alu5 = {4'd0, b5.alu_op};
    assign bc5  = {6'd0, b5.branch_control};
    assign flg5 = {6'd0, b5.illegal_op, b5.mem_error};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect4(input string tag, input logic [7:0] st, input logic [7:0] sb);
        check({tag, ".state"}, st4, st);
        check({tag, ".strobes"}, sb4, sb);
    endtask

    task automatic expect5(input string tag, input logic [7:0] st, input logic [7:0] sb);
        check({tag, ".state"}, st5, st);
        check({tag, ".strobes"}, sb5, sb);
    endtask

    // Inputs change and outputs are sampled 2-3 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset        = 1'b1;
        b4.opcode    = 4'd0;
        b4.cond_flag = 1'b0;
        b4.mem_ready = 1'b0;
        b4.halt_req  = 1'b0;
        b5.opcode    = 5'd0;
        b5.cond_flag = 1'b0;
        b5.mem_ready = 1'b0;
        b5.halt_req  = 1'b1;

        // Reset state
        tick();
        expect4("rst", 8'd0, 8'b00000000);
        check("rst.flags", flg4, 8'b00);
        check("rst.alu", alu4, 8'd0);
        check("rst.bc", bc4, 8'd0);
        reset = 1'b0;

        // IDLE -> FETCH, waiting on memory
        tick();
        expect4("fetch_wait", 8'd1, 8'b00001000);

        // ALU op 1 with memory always ready
        b4.mem_ready = 1'b1;
        b4.opcode    = 4'd1;
        #1;
        expect4("alu_fetch", 8'd1, 8'b10001000);
        tick(); expect4("alu_decode", 8'd2, 8'b00000000);
        tick(); expect4("alu_exec", 8'd3, 8'b00000000);
        check("alu_exec.alu", alu4, 8'd1);
        check("alu_exec.bc", bc4, 8'd0);
        tick(); expect4("alu_wb", 8'd5, 8'b01100000);
        check("alu_wb.alu", alu4, 8'd0);
        tick(); expect4("alu_back", 8'd1, 8'b10001000);

        // BR.C not taken, then taken
        b4.opcode    = 4'd10;
        b4.cond_flag = 1'b0;
        tick(); expect4("brc0_decode", 8'd2, 8'b00000000);
        tick(); expect4("brc0_exec", 8'd3, 8'b00000110);
        check("brc0_exec.bc", bc4, 8'd1);
        check("brc0_exec.alu", alu4, 8'd10);
        tick(); expect4("brc0_fetch", 8'd1, 8'b10001000);
        b4.cond_flag = 1'b1;
        tick();
        tick(); expect4("brc1_exec", 8'd3, 8'b01000110);
        check("brc1_exec.bc", bc4, 8'd1);
        tick(); expect4("brc1_fetch", 8'd1, 8'b10001000);

        // LOAD with three wait cycles in MEM
        b4.opcode = 4'd13;
        tick();
        tick(); expect4("ld_exec", 8'd3, 8'b00000100);
        b4.mem_ready = 1'b0;
        tick(); expect4("ld_mem1", 8'd4, 8'b00001101);
        tick(); expect4("ld_mem2", 8'd4, 8'b00001101);
        tick(); expect4("ld_mem3", 8'd4, 8'b00001101);
        b4.mem_ready = 1'b1;
        #1;
        expect4("ld_mem4", 8'd4, 8'b00001101);
        tick(); expect4("ld_wb", 8'd5, 8'b01100101);
        tick(); expect4("ld_back", 8'd1, 8'b10001000);

        // STORE completing immediately, halt requested at its boundary
        b4.opcode = 4'd14;
        tick();
        tick(); expect4("st_exec", 8'd3, 8'b00000100);
        tick();
        b4.halt_req = 1'b1;
        #1;
        expect4("st_mem", 8'd4, 8'b01010100);
        tick(); expect4("halt_idle", 8'd0, 8'b00000000);
        tick(); expect4("halt_hold", 8'd0, 8'b00000000);
        b4.halt_req = 1'b0;
        tick(); expect4("halt_resume", 8'd1, 8'b10001000);

        // STORE with mem_ready stuck low: cycles 1..16 in MEM, then ERROR
        tick();
        tick();
        b4.mem_ready = 1'b0;
        tick(); expect4("to_mem1", 8'd4, 8'b00010100);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("to_mem%0d.state", i), st4, 8'd4);
        end
        check("to_mem16.flags", flg4, 8'b00);
        tick(); expect4("to_error", 8'd6, 8'b00000000);
        check("to_error.flags", flg4, 8'b01);
        b4.mem_ready = 1'b1;
        tick();
        tick(); expect4("err_hold", 8'd6, 8'b00000000);
        check("err_hold.flags", flg4, 8'b01);

        // Reset leaves ERROR
        reset = 1'b1;
        #1;
        expect4("err_reset", 8'd0, 8'b00000000);
        check("err_reset.flags", flg4, 8'b00);
        tick();
        reset = 1'b0;
        tick(); expect4("err_reset_fetch", 8'd1, 8'b10001000);

        // Reset in the middle of a stalled LOAD
        b4.opcode = 4'd13;
        tick();
        tick();
        b4.mem_ready = 1'b0;
        tick(); expect4("ldr_mem1", 8'd4, 8'b00001101);
        tick(); expect4("ldr_mem2", 8'd4, 8'b00001101);
        reset = 1'b1;
        #1;
        expect4("ldr_reset", 8'd0, 8'b00000000);
        tick(); expect4("ldr_reset_hold", 8'd0, 8'b00000000);
        reset = 1'b0;
        #1;
        expect4("ldr_release", 8'd0, 8'b00000000);
        tick(); expect4("ldr_release_fetch", 8'd1, 8'b00001000);

        // 5-bit opcode instance: illegal opcode acts as NOP, halt at boundary
        expect5("d5_parked", 8'd0, 8'b00000000);
        b5.halt_req  = 1'b0;
        b5.mem_ready = 1'b1;
        b5.opcode    = 5'h13;
        tick(); expect5("d5_fetch", 8'd1, 8'b10001000);
        tick(); expect5("d5_decode", 8'd2, 8'b00000000);
        check("d5_decode.flags", flg5, 8'b00);
        tick(); expect5("d5_exec", 8'd3, 8'b01000000);
        check("d5_exec.flags", flg5, 8'b10);
        check("d5_exec.bc", bc5, 8'd0);
        check("d5_exec.alu", alu5, 8'd3);
        b5.halt_req = 1'b1;
        #1;
        expect5("d5_exec_halt", 8'd3, 8'b01000000);
        tick(); expect5("d5_idle", 8'd0, 8'b00000000);
        check("d5_idle.flags", flg5, 8'b10);
        tick(); expect5("d5_idle_hold", 8'd0, 8'b00000000);
        b5.halt_req = 1'b0;
        b5.opcode   = 5'd1;
        tick(); expect5("d5_resume", 8'd1, 8'b10001000);
        tick();
        tick(); expect5("d5_alu_exec", 8'd3, 8'b00000000);
        check("d5_alu_exec.alu", alu5, 8'd1);
        check("d5_sticky.flags", flg5, 8'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
